// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
interface pipe_ctrl_if #(
    parameter int STALL_W = 6,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32
);
    logic [STALL_W-1:0] stallreq;
    logic               excp_req;
    logic [PC_W-1:0]    excp_pc;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [PC_W-1:0]    new_pc;
    logic [CNT_W-1:0]   stall_cycles;
    logic               stall_timeout;

    modport master (
        output stallreq, excp_req, excp_pc,
        input  stall, flush, new_pc, stall_cycles, stall_timeout
    );

    modport slave (
        input  stallreq, excp_req, excp_pc,
        output stall, flush, new_pc, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: thermometer stall mask, exception flush FSM,
// saturating stall-cycle statistics and a sticky consecutive-stall watchdog.
module pipe_ctrl #(
    parameter int STALL_W   = 6,
    parameter int PC_W      = 32,
    parameter int FLUSH_CYC = 1,
    parameter int TIMEOUT   = 1023,
    parameter int CNT_W     = 32
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [3:0]         fcnt_q, fcnt_d;
    logic [PC_W-1:0]    new_pc_q, new_pc_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [15:0]        run_q, run_d;
    logic               to_q, to_d;
    logic [STALL_W-1:0] therm;
    logic [STALL_W-1:0] stall;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc_run(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // A stall in stage h must also hold every earlier stage, so fill downward.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        therm = '0;
        for (int i = STALL_W - 1; i >= 0; i--) begin
            acc      = acc | bus.stallreq[i];
            therm[i] = acc;
        end
    end

    assign stall = (rst || state_q == FLUSH) ? '0 : therm;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        new_pc_d = new_pc_q;
        unique case (state_q)
            RUN: begin
                if (bus.excp_req) begin
                    state_d  = FLUSH;
                    fcnt_d   = 4'(FLUSH_CYC - 1);
                    new_pc_d = bus.excp_pc;
                end
            end
            FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        scnt_d = stall[0] ? sat_inc_cnt(scnt_q) : scnt_q;
        run_d  = (stall != '0) ? sat_inc_run(run_q) : 16'd0;
        to_d   = to_q | (run_d == 16'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            fcnt_q   <= 4'd0;
            new_pc_q <= '0;
            scnt_q   <= '0;
            run_q    <= 16'd0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            new_pc_q <= new_pc_d;
            scnt_q   <= scnt_d;
            run_q    <= run_d;
            to_q     <= to_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.flush         = (state_q == FLUSH);
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_cycles  = scnt_q;
    assign bus.stall_timeout = to_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two configurations driven in lockstep
// against a cycle model of the controller.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STALL_W(6), .PC_W(32), .CNT_W(3))  if_a ();
    pipe_ctrl_if #(.STALL_W(6), .PC_W(32), .CNT_W(32)) if_b ();

    pipe_ctrl #(.STALL_W(6), .PC_W(32), .FLUSH_CYC(2), .TIMEOUT(4), .CNT_W(3)) u_a (
        .clk(clk), .rst(rst), .bus(if_a.slave)
    );
    pipe_ctrl #(.STALL_W(6), .PC_W(32), .FLUSH_CYC(4), .TIMEOUT(1023), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .bus(if_b.slave)
    );

    typedef struct {
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        to;
    } exp_t;

    logic [5:0] stall_q[$];
    exp_t       reg_q[$];

    int n_vec = 0;
    int n_err = 0;

    // model state, index 0 = instance a, 1 = instance b
    int          m_rem [2];
    logic [31:0] m_pc  [2];
    longint      m_cnt [2];
    int          m_run [2];
    logic        m_to  [2];

    function automatic int fcyc(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int tmo(input int k);
        return (k == 0) ? 4 : 1023;
    endfunction

    function automatic longint cmax(input int k);
        return (k == 0) ? 64'd7 : 64'hFFFF_FFFF;
    endfunction

    function automatic logic [5:0] therm(input logic [5:0] sr);
        int h;
        h = -1;
        for (int i = 0; i < 6; i++) if (sr[i]) h = i;
        if (h < 0) return 6'd0;
        return 6'((1 << (h + 1)) - 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic [5:0] sr, input logic er,
                              input logic [31:0] epc, input logic rs);
        logic [5:0] st;
        st = (rs || m_rem[k] > 0) ? 6'd0 : therm(sr);
        if (rs) begin
            m_rem[k] = 0; m_pc[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_to[k] = 1'b0;
        end else begin
            if (st[0] && m_cnt[k] < cmax(k)) m_cnt[k]++;
            if (st != 6'd0) begin
                if (m_run[k] < 65535) m_run[k]++;
                if (m_run[k] == tmo(k)) m_to[k] = 1'b1;
            end else begin
                m_run[k] = 0;
            end
            if (m_rem[k] > 0) m_rem[k]--;
            else if (er) begin
                m_rem[k] = fcyc(k);
                m_pc[k]  = epc;
            end
        end
    endtask

    task automatic step(input logic [5:0] sr, input logic er, input logic [31:0] epc, input logic rs);
        exp_t e;
        logic [5:0] s;
        @(negedge clk);
        rst = rs;
        if_a.stallreq = sr; if_a.excp_req = er; if_a.excp_pc = epc;
        if_b.stallreq = sr; if_b.excp_req = er; if_b.excp_pc = epc;
        for (int k = 0; k < 2; k++)
            stall_q.push_back((rs || m_rem[k] > 0) ? 6'd0 : therm(sr));
        #1;
        s = stall_q.pop_front(); check_val("a.stall", 32'(if_a.stall), 32'(s));
        s = stall_q.pop_front(); check_val("b.stall", 32'(if_b.stall), 32'(s));
        for (int k = 0; k < 2; k++) begin
            model_edge(k, sr, er, epc, rs);
            e.flush = (m_rem[k] > 0);
            e.pc    = m_pc[k];
            e.cnt   = 32'(m_cnt[k]);
            e.to    = m_to[k];
            reg_q.push_back(e);
        end
        @(posedge clk);
        #1;
        e = reg_q.pop_front();
        check_val("a.flush", 32'(if_a.flush), 32'(e.flush));
        check_val("a.new_pc", if_a.new_pc, e.pc);
        check_val("a.stall_cycles", 32'(if_a.stall_cycles), e.cnt);
        check_val("a.stall_timeout", 32'(if_a.stall_timeout), 32'(e.to));
        e = reg_q.pop_front();
        check_val("b.flush", 32'(if_b.flush), 32'(e.flush));
        check_val("b.new_pc", if_b.new_pc, e.pc);
        check_val("b.stall_cycles", if_b.stall_cycles, e.cnt);
        check_val("b.stall_timeout", 32'(if_b.stall_timeout), 32'(e.to));
    endtask

    task automatic do_reset();
        step(6'd0, 1'b0, 32'd0, 1'b1);
        step(6'd0, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        if_a.stallreq = '0; if_a.excp_req = 1'b0; if_a.excp_pc = '0;
        if_b.stallreq = '0; if_b.excp_req = 1'b0; if_b.excp_pc = '0;
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_pc[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_to[k] = 1'b0;
        end

        do_reset();

        // load-use stall on ID, then deeper requests
        repeat (3) step(6'b000100, 1'b0, 32'd0, 1'b0);
        check_val("dir.cnt3", if_b.stall_cycles, 32'd3);
        step(6'b001000, 1'b0, 32'd0, 1'b0);
        step(6'b001100, 1'b0, 32'd0, 1'b0);
        step(6'b100000, 1'b0, 32'd0, 1'b0);
        step(6'b000000, 1'b0, 32'd0, 1'b0);

        // single exception pulse
        do_reset();
        step(6'd0, 1'b1, 32'hBFC0_0380, 1'b0);
        check_val("dir.pc", if_a.new_pc, 32'hBFC0_0380);
        repeat (5) step(6'd0, 1'b0, 32'd0, 1'b0);

        // exception with concurrent stall, second request ignored
        do_reset();
        step(6'b000100, 1'b1, 32'hBFC0_0380, 1'b0);
        step(6'b000100, 1'b1, 32'h0000_1234, 1'b0);
        check_val("dir.pc_hold", if_b.new_pc, 32'hBFC0_0380);
        repeat (4) step(6'b000100, 1'b0, 32'd0, 1'b0);
        step(6'd0, 1'b0, 32'd0, 1'b0);

        // watchdog: short burst, gap, full burst
        do_reset();
        repeat (3) step(6'b000100, 1'b0, 32'd0, 1'b0);
        check_val("dir.to_clear", 32'(if_a.stall_timeout), 32'd0);
        step(6'd0, 1'b0, 32'd0, 1'b0);
        repeat (4) step(6'b000100, 1'b0, 32'd0, 1'b0);
        check_val("dir.to_set", 32'(if_a.stall_timeout), 32'd1);
        repeat (2) step(6'd0, 1'b0, 32'd0, 1'b0);

        // stall-cycle saturation in the 3-bit instance
        do_reset();
        repeat (10) step(6'b000001, 1'b0, 32'd0, 1'b0);
        check_val("dir.sat7", 32'(if_a.stall_cycles), 32'd7);

        // reset in the middle of a flush, then a fresh exception
        do_reset();
        step(6'b000100, 1'b1, 32'hDEAD_0000, 1'b0);
        step(6'd0, 1'b0, 32'd0, 1'b0);
        step(6'b000100, 1'b1, 32'd0, 1'b1);
        check_val("dir.abort", 32'(if_b.flush), 32'd0);
        step(6'd0, 1'b1, 32'h8000_0180, 1'b0);
        repeat (5) step(6'd0, 1'b0, 32'd0, 1'b0);

        // random mix
        for (int i = 0; i < 80; i++)
            step(6'($urandom), ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 29) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
